// File: rtl/onehot_idx_pkg.sv
// Shared types and helpers for the one-hot index streamer.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package onehot_idx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Widest vector lsb_clear handles; callers zero-extend and truncate around it.
    localparam int LSB_MAXW = 256;

    function automatic logic [LSB_MAXW-1:0] lsb_clear(input logic [LSB_MAXW-1:0] v);
        return v & (v - LSB_MAXW'(1));
    endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder with an any-bit-set flag.
// Latency: combinational.
// Backpressure: not applicable.
module lsb_prio_enc #(
    parameter  int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scanning downwards lets the lowest set bit win.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/onehot_index_streamer.sv
// Streams the index of every set bit of a request vector, LSB first, last beat flagged (out_total with ONEHOT_IDX_POPCNT_EN).
// Latency: first index one cycle after acceptance; one index per cycle, no bubble between vectors.
// Backpressure: out_ready low holds the beat; in_ready only rises on IDLE or a transferring last beat.
module onehot_index_streamer
    import onehot_idx_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none
`ifdef ONEHOT_IDX_POPCNT_EN
    ,
    output logic [IDX_W:0]   out_total
`endif
);

    state_t           state;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] pend_clr;
    logic             none_q;
    logic             pend_any;
    logic             xfer;
    logic             accept;

    lsb_prio_enc #(.WIDTH(WIDTH)) u_enc (
        .vec (pend),
        .idx (out_idx),
        .any (pend_any)
    );

    assign pend_clr  = WIDTH'(lsb_clear(LSB_MAXW'(pend)));
    // An empty pend only occurs for the all-zero vector, which is a single last beat.
    assign out_last  = !pend_any || (pend_clr == '0);
    assign out_valid = (state == EMIT);
    assign out_none  = none_q;
    assign xfer      = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (xfer && out_last);
    assign accept    = in_valid && in_ready;

`ifdef ONEHOT_IDX_POPCNT_EN
    function automatic logic [IDX_W:0] popcnt(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + (IDX_W+1)'(v[i]);
        end
        return c;
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pend   <= '0;
            none_q <= 1'b0;
`ifdef ONEHOT_IDX_POPCNT_EN
            out_total <= '0;
`endif
        end else if (accept) begin
            state  <= EMIT;
            pend   <= in_vec;
            none_q <= (in_vec == '0);
`ifdef ONEHOT_IDX_POPCNT_EN
            out_total <= popcnt(in_vec);
`endif
        end else if (xfer) begin
            pend <= pend_clr;
            if (out_last) begin
                state  <= IDLE;
                none_q <= 1'b0;
            end
        end
    end

endmodule
